// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data requests win over fetch. Only one access is in flight, and a watchdog aborts any access that stalls.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  localparam logic [9:0] TO = 10'(TIMEOUT);

  state_t     state, state_nxt;
  logic [9:0] cnt;
  logic       d_ok, f_ok, busy, done, abort;

  // A requester whose valid is pulsing this cycle is finished, not re-requesting.
  assign d_ok  = d_req & ~d_valid;
  assign f_ok  = if_req & ~if_valid;
  assign busy  = (state != IDLE);
  assign done  = busy & mem_ready;
  // The cycle in which the counter sits at TIMEOUT is the last chance for mem_ready.
  assign abort = busy & ~mem_ready & (cnt == TO);

  assign mem_req  = busy;
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_ok)      state_nxt = DATA;
        else if (f_ok) state_nxt = FETCH;
      end
      FETCH, DATA: begin
        if (done | abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (d_ok) begin
          mem_we    <= d_we;
          mem_be    <= d_be;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else if (f_ok) begin
          mem_we    <= 1'b0;
          mem_be    <= 4'hF;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end else if (done | abort) begin
        if (state == FETCH) begin
          if_valid <= 1'b1;
          if_rdata <= done ? mem_rdata : '0;
        end else begin
          d_valid <= 1'b1;
          d_rdata <= (done & ~mem_we) ? mem_rdata : '0;
        end
        if (abort) bus_err <= 1'b1;
      end else begin
        cnt <= cnt + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4). Inputs change and outputs are checked just after the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, if_stall, d_valid, d_stall, mem_req, mem_we, bus_err;
  logic [3:0]  mem_be;

  int vectors = 0;
  int misses  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0; d_be = 0;
    cyc(); cyc(); #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_bus_err", bus_err, 0);

    // Fetch only
    cyc(); rst = 0; if_req = 1; if_addr = 32'h100; #1;
    chk("f1_stall", if_stall, 1);
    chk("f1_idle_mem_req", mem_req, 0);
    cyc(); #1;
    chk("f1_mem_req", mem_req, 1);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_mem_we", mem_we, 0);
    chk("f1_mem_be", mem_be, 4'hF);
    chk("f1_no_valid", if_valid, 0);
    mem_ready = 1; mem_rdata = 32'h13;
    cyc(); mem_ready = 0; #1;
    chk("f1_valid", if_valid, 1);
    chk("f1_rdata", if_rdata, 32'h13);
    chk("f1_stall_falls", if_stall, 0);
    chk("f1_mem_req_off", mem_req, 0);
    if_req = 0;
    cyc(); #1;
    chk("f1_valid_pulse", if_valid, 0);

    // Simultaneous: data wins, fetch granted in d_valid cycle
    if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h2000;
    #1;
    chk("s_if_stall0", if_stall, 1);
    chk("s_d_stall0", d_stall, 1);
    cyc(); #1;
    chk("s_mem_addr_d", mem_addr, 32'h2000);
    chk("s_mem_we", mem_we, 0);
    chk("s_if_stall1", if_stall, 1);
    mem_ready = 1; mem_rdata = 32'hCAFE0001;
    cyc(); mem_ready = 0; #1;
    chk("s_d_valid", d_valid, 1);
    chk("s_d_rdata", d_rdata, 32'hCAFE0001);
    chk("s_d_stall", d_stall, 0);
    chk("s_if_stall2", if_stall, 1);
    chk("s_if_valid_none", if_valid, 0);
    d_req = 0;
    cyc(); #1;
    chk("s_fetch_granted", mem_req, 1);
    chk("s_mem_addr_f", mem_addr, 32'h104);
    chk("s_d_valid_pulse", d_valid, 0);
    chk("s_if_stall3", if_stall, 1);
    mem_ready = 1; mem_rdata = 32'h00500093;
    cyc(); mem_ready = 0; #1;
    chk("s_if_valid", if_valid, 1);
    chk("s_if_rdata", if_rdata, 32'h00500093);
    if_req = 0;
    cyc(); #1;
    chk("s_if_valid_pulse", if_valid, 0);

    // Store: command held constant even if inputs wander
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h3004; d_wdata = 32'hDEADBEEF;
    cyc(); #1;
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_be", mem_be, 4'b0011);
    chk("st_mem_addr", mem_addr, 32'h3004);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    d_addr = 32'h0; d_wdata = 32'h12345678; d_be = 4'hC;
    cyc(); #1;
    chk("st_hold_addr", mem_addr, 32'h3004);
    chk("st_hold_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_hold_be", mem_be, 4'b0011);
    mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
    cyc(); mem_ready = 0; #1;
    chk("st_d_valid", d_valid, 1);
    chk("st_d_rdata_zero", d_rdata, 0);
    chk("st_no_err", bus_err, 0);
    d_req = 0;
    cyc(); #1;
    chk("st_valid_pulse", d_valid, 0);

    // Timeout: 4 wait cycles, abort decided in the 5th busy cycle
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h4000; mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("to_busy", mem_req, 1);
      chk("to_no_valid", d_valid, 0);
    end
    cyc(); #1;
    chk("to_d_valid", d_valid, 1);
    chk("to_d_rdata_zero", d_rdata, 0);
    chk("to_bus_err", bus_err, 1);
    chk("to_idle", mem_req, 0);
    d_req = 0; mem_ready = 1;
    cyc(); mem_ready = 0; #1;
    chk("idle_ready_ignored", d_valid | if_valid, 0);
    chk("to_err_sticky", bus_err, 1);

    // mem_ready on the TIMEOUT cycle completes normally
    if_req = 1; if_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("tb_busy", mem_req, 1);
    end
    cyc(); #1;
    chk("tb_busy_last", mem_req, 1);
    mem_ready = 1; mem_rdata = 32'h11112222;
    cyc(); mem_ready = 0; #1;
    chk("tb_if_valid", if_valid, 1);
    chk("tb_if_rdata", if_rdata, 32'h11112222);
    chk("tb_err_sticky", bus_err, 1);
    if_req = 0;

    // Reset mid-DATA, then a late mem_ready
    cyc(); d_req = 1; d_we = 1; d_be = 4'h5; d_addr = 32'h5000; d_wdata = 32'hA5A5A5A5;
    cyc(); #1;
    chk("rd_busy", mem_req, 1);
    chk("rd_mem_addr", mem_addr, 32'h5000);
    rst = 1;
    cyc(); rst = 0; d_req = 0; mem_ready = 1; mem_rdata = 32'h77; #1;
    chk("rd_mem_req", mem_req, 0);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_be", mem_be, 0);
    chk("rd_mem_addr0", mem_addr, 0);
    chk("rd_mem_wdata", mem_wdata, 0);
    chk("rd_bus_err", bus_err, 0);
    chk("rd_if_rdata", if_rdata, 0);
    cyc(); mem_ready = 0; #1;
    chk("rd_no_d_valid", d_valid, 0);
    chk("rd_d_rdata", d_rdata, 0);
    chk("rd_still_idle", mem_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
